// File: rtl/fpga_io_pkg.sv
// Shared types and constants for the FPGA I/O bridge.
// The debouncer state enum is only used when FPGA_IO_BRIDGE_DEBOUNCE_EN is defined.
package fpga_io_pkg;

    typedef enum logic [1:0] {
        LOW,
        WAIT_HIGH,
        HIGH,
        WAIT_LOW
    } db_state_e;

    localparam int LED_R = 0;
    localparam int LED_G = 1;
    localparam int LED_B = 2;

    localparam int DEF_NUM_IO          = 13;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 480000;
    localparam int DEF_RST_STRETCH     = 16;
    localparam int DEF_PWM_BITS        = 8;
    localparam int DEF_LED_ACTIVE_LOW  = 1;

endpackage

// File: rtl/fpga_io_debounce.sv
// User button conditioning: synchronizer followed by an optional debounce FSM.
// FPGA_IO_BRIDGE_DEBOUNCE_EN selects the FSM; otherwise the synced level is passed through.
module fpga_io_debounce
    import fpga_io_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    logic [SYNC_STAGES-1:0] btnSync_q;
    logic                   btnSynced;
    logic                   press_q;
    logic                   press_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btnSync_q <= '0;
        end else begin
            btnSync_q <= {btnSync_q[SYNC_STAGES-2:0], btn_i};
        end
    end

    assign btnSynced = btnSync_q[SYNC_STAGES-1];

`ifdef FPGA_IO_BRIDGE_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LOW;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // A WAIT state is left before the counter could pass CNT_LAST, so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        case (state_q)
            LOW: begin
                if (btnSynced) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!btnSynced) begin
                    state_d = LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (!btnSynced) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (btnSynced) begin
                    state_d = HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = LOW;
        endcase
    end

    assign level_o = (state_q == HIGH) || (state_q == WAIT_LOW);
`else
    logic btnPrev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btnPrev_q <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            btnPrev_q <= btnSynced;
            press_q   <= press_d;
        end
    end

    assign press_d = btnSynced & ~btnPrev_q;
    assign level_o = btnSynced;
`endif

    assign press_o = press_q;

endmodule

// File: rtl/fpga_io_bridge.sv
// Board-level glue between pads and an emulated core: GPIO sync/drive, reset stretch,
// button conditioning and RGB LED PWM. Button debounce enabled by FPGA_IO_BRIDGE_DEBOUNCE_EN.
module fpga_io_bridge
    import fpga_io_pkg::*;
#(
    parameter int NUM_IO          = DEF_NUM_IO,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int RST_STRETCH     = DEF_RST_STRETCH,
    parameter int PWM_BITS        = DEF_PWM_BITS,
    parameter int LED_ACTIVE_LOW  = DEF_LED_ACTIVE_LOW
) (
    input  logic                clk48,
    input  logic                rst_n,
    input  logic [NUM_IO-1:0]   pad_in,
    output logic [NUM_IO-1:0]   pad_out,
    output logic [NUM_IO-1:0]   pad_oe,
    output logic [NUM_IO-1:0]   core_io_in,
    input  logic [NUM_IO-1:0]   core_io_out,
    input  logic [NUM_IO-1:0]   core_io_oeb,
    output logic                core_rst,
    input  logic                btn_raw,
    output logic                btn_level,
    output logic                btn_press,
    input  logic [2:0]          led_req,
    input  logic [PWM_BITS-1:0] led_duty,
    output logic [2:0]          rgb_led
);

    localparam int RST_W = $clog2(RST_STRETCH + 1) > 0 ? $clog2(RST_STRETCH + 1) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_STRETCH);
    localparam logic [2:0] LED_OFF = (LED_ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

    logic [NUM_IO-1:0]   padSync_q [SYNC_STAGES];
    logic [NUM_IO-1:0]   padOut_q;
    logic [NUM_IO-1:0]   padOe_q;
    logic [RST_W-1:0]    stretchCnt_q;
    logic                coreRst_q;
    logic [PWM_BITS-1:0] pwmCnt_q;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] dutyEff;
    logic                dutyHit;
    logic [2:0]          ledActive;
    logic [2:0]          rgb_q;

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                padSync_q[s] <= '0;
            end
            padOut_q <= '0;
            padOe_q  <= '0;
        end else begin
            padSync_q[0] <= pad_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                padSync_q[s] <= padSync_q[s-1];
            end
            padOut_q <= core_io_out;
            padOe_q  <= ~core_io_oeb;
        end
    end

    assign core_io_in = padSync_q[SYNC_STAGES-1];
    assign pad_out    = padOut_q;
    assign pad_oe     = padOe_q;

    // Edge 1 after release leaves the counter at 1, so release lands on edge RST_STRETCH+1.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            stretchCnt_q <= '0;
            coreRst_q    <= 1'b1;
        end else if (coreRst_q) begin
            if (stretchCnt_q == RST_LAST) begin
                coreRst_q <= 1'b0;
            end else begin
                stretchCnt_q <= stretchCnt_q + 1'b1;
            end
        end
    end

    assign core_rst = coreRst_q;

    fpga_io_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i   (clk48),
        .rst_ni  (rst_n),
        .btn_i   (btn_raw),
        .level_o (btn_level),
        .press_o (btn_press)
    );

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            pwmCnt_q <= '0;
            duty_q   <= '0;
            rgb_q    <= LED_OFF;
        end else begin
            pwmCnt_q <= pwmCnt_q + 1'b1;
            if (pwmCnt_q == '0) begin
                duty_q <= led_duty;
            end
            rgb_q <= ledActive ^ LED_OFF;
        end
    end

    // The period-start slot already uses the freshly sampled duty.
    always_comb begin
        dutyEff = (pwmCnt_q == '0) ? led_duty : duty_q;
        dutyHit = (&dutyEff) || (pwmCnt_q < dutyEff);
        ledActive        = '0;
        ledActive[LED_R] = led_req[LED_R] & dutyHit;
        ledActive[LED_G] = led_req[LED_G] & dutyHit;
        ledActive[LED_B] = led_req[LED_B] & dutyHit;
    end

    assign rgb_led = rgb_q;

endmodule

// File: tb/tb_fpga_io_bridge.sv
// Directed self-checking bench for fpga_io_bridge: table-driven GPIO and PWM vectors plus
// hand-written reset-stretch, latency, button and duty-resampling sequences.
module tb_fpga_io_bridge;

    localparam int NUM_IO = 13;
    localparam int PWM_BITS = 8;

    typedef struct {
        logic [12:0] padIn;
        logic [12:0] ioOut;
        logic [12:0] ioOeb;
        logic [12:0] expCoreIn;
        logic [12:0] expPadOut;
        logic [12:0] expPadOe;
    } io_vec_t;

    typedef struct {
        logic [2:0] req;
        logic [7:0] duty;
        int         expR;
        int         expG;
        int         expB;
    } pwm_vec_t;

    logic                clk48 = 1'b0;
    logic                rst_n;
    logic [NUM_IO-1:0]   pad_in;
    logic [NUM_IO-1:0]   pad_out;
    logic [NUM_IO-1:0]   pad_oe;
    logic [NUM_IO-1:0]   core_io_in;
    logic [NUM_IO-1:0]   core_io_out;
    logic [NUM_IO-1:0]   core_io_oeb;
    logic                core_rst;
    logic                btn_raw;
    logic                btn_level;
    logic                btn_press;
    logic [2:0]          led_req;
    logic [PWM_BITS-1:0] led_duty;
    logic [2:0]          rgb_led;

    int vectorCount = 0;
    int missCount   = 0;

    io_vec_t  ioTable[5];
    pwm_vec_t pwmTable[5];

    always #5 clk48 = ~clk48;

    fpga_io_bridge #(
        .NUM_IO          (NUM_IO),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8),
        .RST_STRETCH     (16),
        .PWM_BITS        (PWM_BITS),
        .LED_ACTIVE_LOW  (1)
    ) dut (
        .clk48       (clk48),
        .rst_n       (rst_n),
        .pad_in      (pad_in),
        .pad_out     (pad_out),
        .pad_oe      (pad_oe),
        .core_io_in  (core_io_in),
        .core_io_out (core_io_out),
        .core_io_oeb (core_io_oeb),
        .core_rst    (core_rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .led_req     (led_req),
        .led_duty    (led_duty),
        .rgb_led     (rgb_led)
    );

    task automatic tick();
        @(posedge clk48);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [12:0] pIn, input logic [12:0] oOut, input logic [12:0] oOeb);
        pad_in      = pIn;
        core_io_out = oOut;
        core_io_oeb = oOeb;
    endtask

    // Active-low pads: a channel is lit when its bit reads 0.
    task automatic countActive(input int cycles, output int cntR, output int cntG, output int cntB);
        cntR = 0;
        cntG = 0;
        cntB = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (rgb_led[0] == 1'b0) cntR++;
            if (rgb_led[1] == 1'b0) cntG++;
            if (rgb_led[2] == 1'b0) cntB++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        int  cR, cG, cB;
        int  pressCount;
        int  levelSeen;
        bit  found;
        logic prevR;

        ioTable[0] = '{13'h0000, 13'h1FFF, 13'h0000, 13'h0000, 13'h1FFF, 13'h1FFF};
        ioTable[1] = '{13'h1FFF, 13'h0000, 13'h1FFF, 13'h1FFF, 13'h0000, 13'h0000};
        ioTable[2] = '{13'h1555, 13'h0AAA, 13'h00FF, 13'h1555, 13'h0AAA, 13'h1F00};
        ioTable[3] = '{13'h0AAA, 13'h1234, 13'h1F00, 13'h0AAA, 13'h1234, 13'h00FF};
        ioTable[4] = '{13'h1001, 13'h0001, 13'h1FFE, 13'h1001, 13'h0001, 13'h0001};

        pwmTable[0] = '{3'b001, 8'd64,  64,  0,   0};
        pwmTable[1] = '{3'b001, 8'd0,   0,   0,   0};
        pwmTable[2] = '{3'b001, 8'd255, 256, 0,   0};
        pwmTable[3] = '{3'b110, 8'd128, 0,   128, 128};
        pwmTable[4] = '{3'b111, 8'd1,   1,   1,   1};

        rst_n = 1'b0;
        applyStimulus(13'h1FFF, 13'h1FFF, 13'h0000);
        btn_raw  = 1'b0;
        led_req  = 3'b111;
        led_duty = 8'd255;
        repeat (3) tick();
        checkOutput("reset.pad_oe", 32'(pad_oe), 32'h0);
        checkOutput("reset.pad_out", 32'(pad_out), 32'h0);
        checkOutput("reset.core_io_in", 32'(core_io_in), 32'h0);
        checkOutput("reset.core_rst", 32'(core_rst), 32'h1);
        checkOutput("reset.btn_level", 32'(btn_level), 32'h0);
        checkOutput("reset.btn_press", 32'(btn_press), 32'h0);
        checkOutput("reset.rgb_led", 32'(rgb_led), 32'h7);

        $display("[TB] reset stretch");
        led_req = 3'b000;
        applyStimulus(13'h0000, 13'h0000, 13'h1FFF);
        rst_n = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            tick();
            checkOutput($sformatf("stretch.edge%0d", n), 32'(core_rst), (n <= 16) ? 32'h1 : 32'h0);
        end

        rst_n = 1'b0;
        #2;
        checkOutput("stretch.async_assert", 32'(core_rst), 32'h1);
        rst_n = 1'b1;
        repeat (8) tick();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            tick();
            if (n >= 8) begin
                checkOutput($sformatf("restart.edge%0d", n), 32'(core_rst), (n <= 16) ? 32'h1 : 32'h0);
            end
        end

        $display("[TB] GPIO vectors");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(ioTable[i].padIn, ioTable[i].ioOut, ioTable[i].ioOeb);
            tick();
            tick();
            checkOutput($sformatf("io[%0d].core_io_in", i), 32'(core_io_in), 32'(ioTable[i].expCoreIn));
            checkOutput($sformatf("io[%0d].pad_out", i), 32'(pad_out), 32'(ioTable[i].expPadOut));
            checkOutput($sformatf("io[%0d].pad_oe", i), 32'(pad_oe), 32'(ioTable[i].expPadOe));
        end

        applyStimulus(13'h0000, 13'h0000, 13'h1FFF);
        tick();
        tick();
        pad_in[3]      = 1'b1;
        core_io_oeb[5] = 1'b0;
        core_io_out[5] = 1'b1;
        tick();
        checkOutput("lat.core_io_in3_c1", 32'(core_io_in[3]), 32'h0);
        checkOutput("lat.pad_oe5_c1", 32'(pad_oe[5]), 32'h1);
        checkOutput("lat.pad_out5_c1", 32'(pad_out[5]), 32'h1);
        tick();
        checkOutput("lat.core_io_in3_c2", 32'(core_io_in[3]), 32'h1);

        $display("[TB] button");
`ifdef FPGA_IO_BRIDGE_DEBOUNCE_EN
        pressCount = 0;
        levelSeen  = 0;
        btn_raw = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) btn_raw = 1'b0;
            tick();
            if (btn_press) pressCount++;
            if (btn_level) levelSeen++;
        end
        checkOutput("db.bounce_press", 32'(pressCount), 32'h0);
        checkOutput("db.bounce_level", 32'(levelSeen), 32'h0);
        pressCount = 0;
        btn_raw = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (btn_press) pressCount++;
        end
        checkOutput("db.hold_press", 32'(pressCount), 32'h1);
        checkOutput("db.hold_level", 32'(btn_level), 32'h1);
        pressCount = 0;
        btn_raw = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (btn_press) pressCount++;
        end
        checkOutput("db.release_press", 32'(pressCount), 32'h0);
        checkOutput("db.release_level", 32'(btn_level), 32'h0);
`else
        btn_raw = 1'b1;
        tick();
        checkOutput("btn.e1_level", 32'(btn_level), 32'h0);
        checkOutput("btn.e1_press", 32'(btn_press), 32'h0);
        tick();
        checkOutput("btn.e2_level", 32'(btn_level), 32'h1);
        checkOutput("btn.e2_press", 32'(btn_press), 32'h0);
        btn_raw = 1'b0;
        tick();
        checkOutput("btn.e3_level", 32'(btn_level), 32'h1);
        checkOutput("btn.e3_press", 32'(btn_press), 32'h1);
        tick();
        checkOutput("btn.e4_level", 32'(btn_level), 32'h0);
        checkOutput("btn.e4_press", 32'(btn_press), 32'h0);
        tick();
        checkOutput("btn.e5_press", 32'(btn_press), 32'h0);
`endif

        $display("[TB] PWM vectors");
        for (int i = 0; i < 5; i++) begin
            led_req  = pwmTable[i].req;
            led_duty = pwmTable[i].duty;
            repeat (260) tick();
            countActive(256, cR, cG, cB);
            checkOutput($sformatf("pwm[%0d].R", i), 32'(cR), 32'(pwmTable[i].expR));
            checkOutput($sformatf("pwm[%0d].G", i), 32'(cG), 32'(pwmTable[i].expG));
            checkOutput($sformatf("pwm[%0d].B", i), 32'(cB), 32'(pwmTable[i].expB));
        end

        $display("[TB] duty resample");
        led_req  = 3'b001;
        led_duty = 8'd64;
        repeat (260) tick();
        found = 1'b0;
        for (int c = 0; c < 600 && !found; c++) begin
            prevR = rgb_led[0];
            tick();
            if (prevR == 1'b1 && rgb_led[0] == 1'b0) found = 1'b1;
        end
        checkOutput("resample.period_start_found", 32'(found), 32'h1);
        repeat (99) tick();
        led_duty = 8'd200;
        countActive(156, cR, cG, cB);
        checkOutput("resample.old_duty_tail", 32'(cR), 32'h0);
        countActive(256, cR, cG, cB);
        checkOutput("resample.new_duty_period", 32'(cR), 32'd200);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/fpga_io_bridge.md
FPGA_IO_BRIDGE -- requirements
Module: fpga_io_bridge

Interface
REQ-001 SHALL have parameter NUM_IO, default 13, number of bidirectional GPIO channels.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth (legal 2..4).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 480000, stable-input cycles (10 ms at 48 MHz) needed to accept a button change.
REQ-004 SHALL have parameter RST_STRETCH, default 16, cycles core_rst is held after rst_n release.
REQ-005 SHALL have parameter PWM_BITS, default 8, LED brightness resolution.
REQ-006 SHALL have parameter LED_ACTIVE_LOW, default 1, LED pad polarity.
REQ-007 clk48  in  1  sole clock; rst_n  in  1  asynchronous, active-low reset.
REQ-008 pad_in  in  NUM_IO  raw pad values from the tristate buffers.
REQ-009 pad_out  out  NUM_IO  registered drive value to pads; pad_oe  out  NUM_IO  1 = drive pad.
REQ-010 core_io_in  out  NUM_IO  synchronized pad values to core; core_io_out  in  NUM_IO; core_io_oeb  in  NUM_IO  1 = core releases pad.
REQ-011 core_rst  out  1  active-high reset to the emulated core.
REQ-012 btn_raw  in  1  asynchronous user button; btn_level  out  1  debounced level; btn_press  out  1  one-cycle pulse on accepted press.
REQ-013 led_req  in  3  R,G,B enables from core; led_duty  in  PWM_BITS  brightness; rgb_led  out  3  LED pad drive.

Function
REQ-014 core_io_in[i] SHALL equal pad_in[i] delayed by exactly SYNC_STAGES cycles.
REQ-015 pad_out and pad_oe SHALL be registered: pad_out <= core_io_out, pad_oe <= ~core_io_oeb, latency 1 cycle.
REQ-016 core_rst SHALL assert asynchronously on rst_n low and deassert synchronously exactly RST_STRETCH cycles after the first clk48 edge with rst_n high.
REQ-017 rst_n re-asserted mid-stretch SHALL restart the stretch counter from zero.
REQ-018 btn_raw SHALL pass a SYNC_STAGES synchronizer before any logic.
REQ-019 Debouncer FSM states: LOW, WAIT_HIGH, HIGH, WAIT_LOW; btn_level = 1 in HIGH and WAIT_LOW.
REQ-020 LOW->WAIT_HIGH when synced button = 1; WAIT_HIGH->LOW when it returns to 0 before count done; WAIT_HIGH->HIGH when counter reaches DEBOUNCE_CYCLES-1; HIGH/WAIT_LOW symmetric.
REQ-021 Debounce counter SHALL clear on every entry to a WAIT state and never wrap.
REQ-022 btn_press SHALL pulse high for exactly one cycle on the WAIT_HIGH->HIGH transition; no pulse on release.
REQ-023 PWM counter SHALL be free-running PWM_BITS wide, wrapping 2^PWM_BITS-1 -> 0.
REQ-024 LED channel i active when led_req[i]=1 and (pwm_cnt < led_duty, or led_duty all-ones); duty 0 = always off.
REQ-025 rgb_led = active XOR LED_ACTIVE_LOW, registered, 1 cycle latency.
REQ-026 led_duty SHALL be sampled only at pwm_cnt = 0 to avoid mid-period glitches.

Reset
REQ-027 During rst_n low: pad_oe = 0, pad_out = 0, core_io_in = 0, synchronizers 0, core_rst = 1.
REQ-028 During rst_n low: FSM = LOW, btn_level = 0, btn_press = 0, pwm_cnt = 0, sampled duty = 0, rgb_led = all LEDs off (0b111 when LED_ACTIVE_LOW=1).

Configuration
REQ-029 Macro FPGA_IO_BRIDGE_DEBOUNCE_EN defined: debouncer per REQ-019..022 compiled in.
REQ-030 Macro undefined: no FSM/counter; btn_level = synced button, btn_press = one-cycle pulse on its rising edge; DEBOUNCE_CYCLES ignored.

Structure
REQ-031 Shared package fpga_io_pkg SHALL hold debouncer state enum, LED channel index constants (R=0,G=1,B=2) and default parameter constants.
REQ-032 Sub-module fpga_io_debounce SHALL contain the synchronizer-fed FSM and counter; everything else flat in fpga_io_bridge.

Verification
REQ-033 Reset release with RST_STRETCH=16 -> core_rst falls exactly 16 cycles after first edge with rst_n=1; rst_n pulse low at cycle 8 -> count restarts.
REQ-034 pad_in[3] toggles 0->1 -> core_io_in[3] = 1 exactly 2 cycles later; core_io_oeb[5]=0, core_io_out[5]=1 -> pad_oe[5]=1, pad_out[5]=1 after 1 cycle.
REQ-035 DEBOUNCE_CYCLES=8, btn_raw bounces high 5 cycles then low -> no btn_press, btn_level stays 0; held high 20 cycles -> single btn_press, btn_level=1.
REQ-036 PWM_BITS=8, led_req=3'b001, led_duty=64 -> R active 64 of 256 cycles; duty=0 -> never; duty=255 -> always; rgb_led polarity inverted per LED_ACTIVE_LOW=1.
REQ-037 led_duty changed at pwm_cnt=100 -> new duty takes effect only from next pwm_cnt=0.
REQ-038 Macro undefined build: btn_raw high 2 cycles -> btn_press one cycle after synchronizer latency, btn_level follows synced input.
